exp_sequencer: RTL and testbench
================================

EXP_SEQUENCER -- requirements
Module: exp_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, input FIFO entries (power of 2, 2..16).
REQ-002 Parameter: TIMEOUT, 255, max cycles in WAIT before error (1..255).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 Port: in_valid  in  1  upstream x sample valid.
REQ-006 Port: in_ready  out  1  sequencer can accept a sample (= FIFO not full).
REQ-007 Port: in_x  in  16  unsigned fraction x, binary point left of bit 15.
REQ-008 Port: exp_start  out  1  one-cycle start pulse to exponential core.
REQ-009 Port: exp_x  out  16  operand to core, held stable from start until done captured.
REQ-010 Port: exp_done  in  1  core completion flag.
REQ-011 Port: exp_int  in  2  integer part of core result.
REQ-012 Port: exp_frac  in  16  fractional part of core result.
REQ-013 Port: out_valid  out  1  result valid to downstream.
REQ-014 Port: out_ready  in  1  downstream accepts result.
REQ-015 Port: out_data  out  18  {exp_int, exp_frac} as captured.
REQ-016 Port: err_timeout  out  1  sticky: core failed to finish within TIMEOUT.
REQ-017 Port: done_cnt  out  8  count of results accepted downstream, wraps 255->0.

Function
REQ-018 Input push when in_valid && in_ready; FIFO order preserved; no push when full, regardless of in_valid.
REQ-019 FSM states IDLE, START, WAIT, HOLD; one state per cycle minimum.
REQ-020 IDLE: FIFO non-empty -> pop head into exp_x register, go START; else stay.
REQ-021 START: exp_start=1 for exactly this cycle, go WAIT; wait counter cleared to 0.
REQ-022 WAIT: exp_done=1 -> capture {exp_int,exp_frac} into out_data, out_valid=1 next cycle, go HOLD; else counter +1.
REQ-023 WAIT: counter reaching TIMEOUT without exp_done -> set err_timeout, out_data=18'h0 with out_valid=1, go HOLD.
REQ-024 HOLD: out_valid=1, out_data stable; out_ready=1 -> out_valid=0 next cycle, done_cnt+1, go IDLE.
REQ-025 exp_done ignored in IDLE, START, HOLD; only first exp_done cycle in WAIT is captured.
REQ-026 exp_x changes only on IDLE->START transition.
REQ-027 Push into FIFO permitted in every state, including same cycle as pop; pop of empty FIFO never occurs.
REQ-028 Same-cycle push and pop on full FIFO impossible (in_ready=0 when full); on non-full FIFO both occur, occupancy unchanged.
REQ-029 Pushed sample visible to IDLE pop no earlier than next cycle (empty FIFO: push at cycle n, START at n+2).
REQ-030 Minimum throughput: one result per 4 cycles + core latency, given out_ready held 1.
REQ-031 err_timeout cleared only by reset.

Reset
REQ-032 rst=0 at a clock edge: FSM->IDLE, FIFO emptied, exp_start=0, exp_x=0, out_valid=0, out_data=0, err_timeout=0, done_cnt=0, in_ready=0 during reset cycle.
REQ-033 Reset mid-operation (any state) discards in-flight operand and all queued samples; no result emitted.
REQ-034 Core shares rst; sequencer makes no assumption about core state after reset beyond done=0.

Verification
REQ-035 Single sample: push x=16'h8000, core model done after 10 cycles with {2'b01,16'hA612} -> exp_start one pulse, out_data=18'h1A612, out_valid until out_ready, done_cnt=1.
REQ-036 Backpressure: push 6 samples back-to-back with DEPTH=4, out_ready=0 -> in_ready drops after 4 stored plus 1 in flight; all 6 results emerge in order once out_ready=1.
REQ-037 Timeout: core model never asserts done, TIMEOUT=20 -> err_timeout=1 at cycle 20 of WAIT, out_data=0 emitted, next sample still processed.
REQ-038 Spurious done: exp_done pulsed in IDLE and HOLD -> no capture, no state change, out_data unchanged.
REQ-039 Reset mid-WAIT with 3 queued samples -> all outputs at reset values next cycle, no out_valid afterwards without new pushes.
REQ-040 done_cnt wrap: 256 completed results -> done_cnt returns to 0.

Source files
------------

// File: rtl/exp_sequencer.sv
// Exponential-core sequencer.
// Buffers unsigned fractional x samples in a small FIFO, hands them one at a
// time to an external exponential core (start pulse + held operand), waits for
// the core to finish (with a bounded wait), and presents each 18-bit result
// downstream with a valid/ready handshake. A core that never finishes yields a
// zero result and a sticky timeout flag so the pipeline keeps moving.
module exp_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    output logic        exp_start,
    output logic [15:0] exp_x,
    input  logic        exp_done,
    input  logic [1:0]  exp_int,
    input  logic [15:0] exp_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] out_data,
    output logic        err_timeout,
    output logic [7:0]  done_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        HOLD
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping
    logic [15:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Sequencer datapath
    logic [15:0] x_q, x_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [17:0] data_q, data_d;
    logic        err_q, err_d;
    logic [7:0]  done_cnt_q, done_cnt_d;

    assign fifo_full  = (count_q == DEPTH_C);
    assign fifo_empty = (count_q == '0);

    // Holding rst low also closes the input so nothing is accepted in the
    // reset cycle.
    assign in_ready = rst && !fifo_full;
    assign push     = in_valid && in_ready;
    // Pops only happen from IDLE with data present, so an empty pop is impossible.
    assign pop      = (state_q == IDLE) && !fifo_empty;

    assign exp_start   = (state_q == START);
    assign exp_x       = x_q;
    assign out_valid   = (state_q == HOLD);
    assign out_data    = data_q;
    assign err_timeout = err_q;
    assign done_cnt    = done_cnt_q;

    // FIFO pointer and occupancy next-state; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_x;
        end
    end

    // Sequencer next-state: issue, bounded wait, capture, and hand-off.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        wait_cnt_d = wait_cnt_q;
        data_d     = data_q;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    x_d     = fifo_mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // A done on the last permitted cycle still wins over the timeout.
                if (exp_done) begin
                    data_d  = {exp_int, exp_frac};
                    state_d = HOLD;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            x_q        <= '0;
            wait_cnt_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            x_q        <= x_d;
            wait_cnt_q <= wait_cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_exp_sequencer.sv
// Self-checking bench for exp_sequencer: a behavioural exp-core model driven
// from a per-sample plan, an output monitor, and a reference rule set
// (result = planned core value if the core finishes within TIMEOUT, else 0).
module tb_exp_sequencer;

    localparam int TO  = 20;
    localparam int DEP = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        in_valid  = 1'b0;
    logic [15:0] in_x      = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        exp_start;
    logic [15:0] exp_x;
    logic        exp_done;
    logic [1:0]  exp_int;
    logic [15:0] exp_frac;
    logic        out_valid;
    logic [17:0] out_data;
    logic        err_timeout;
    logic [7:0]  done_cnt;

    // core model outputs and spurious-done injection
    logic        core_done = 1'b0;
    logic [17:0] core_bus  = '0;
    logic [17:0] core_cur  = '0;
    logic        spur_done = 1'b0;
    logic        spur_en   = 1'b0;
    logic [17:0] spur_val  = '0;

    assign exp_done = core_done | spur_done;
    assign exp_int  = spur_en ? spur_val[17:16] : core_bus[17:16];
    assign exp_frac = spur_en ? spur_val[15:0]  : core_bus[15:0];

    exp_sequencer #(.DEPTH(DEP), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .exp_start  (exp_start),
        .exp_x      (exp_x),
        .exp_done   (exp_done),
        .exp_int    (exp_int),
        .exp_frac   (exp_frac),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err_timeout(err_timeout),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // plan: every accepted sample with its core latency (-1 = never) and value
    logic [15:0] plan_x[$];
    int          plan_lat[$];
    logic [17:0] plan_res[$];
    // observations from the monitor
    logic [17:0] obs_out[$];
    logic [15:0] obs_x[$];
    int          n_starts  = 0;
    int          start_cyc = 0;
    // bases: plan/obs indices where the current post-reset epoch begins
    int pb = 0, ob = 0, xb = 0, chk = 0;

    // Core model: done pulses L cycles after the start cycle; bus carries noise otherwise.
    int core_left = 0;
    int core_idx  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            core_left = 0;
            core_done = 1'b0;
            core_idx  = plan_x.size();
        end else begin
            core_done = 1'b0;
            core_bus  = 18'($urandom);
            if (core_left > 0) begin
                core_left = core_left - 1;
                if (core_left == 0) begin
                    core_done = 1'b1;
                    core_bus  = core_cur;
                end
            end
            if (exp_start && core_idx < plan_lat.size()) begin
                core_left = (plan_lat[core_idx] > 0) ? plan_lat[core_idx] : 0;
                core_cur  = plan_res[core_idx];
                core_idx++;
            end
        end
    end

    // Monitor: downstream handshakes and issued operands.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) obs_out.push_back(out_data);
            if (exp_start) begin
                obs_x.push_back(exp_x);
                n_starts++;
                start_cyc = cyc;
            end
        end
    end

    function automatic logic [17:0] model_out(int i);
        if (plan_lat[i] >= 1 && plan_lat[i] <= TO) return plan_res[i];
        return 18'h0;
    endfunction

    function automatic logic model_err();
        for (int i = pb; i < plan_lat.size(); i++)
            if (!(plan_lat[i] >= 1 && plan_lat[i] <= TO)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] x, input int lat, input logic [17:0] res,
                            output bit ok, output int pcyc);
        int guard = 0;
        in_valid = 1'b1;
        in_x     = x;
        while (in_ready !== 1'b1 && guard < 500) begin
            tick();
            guard++;
        end
        ok   = (in_ready === 1'b1);
        pcyc = cyc;
        if (ok) begin
            plan_x.push_back(x);
            plan_lat.push_back(lat);
            plan_res.push_back(res);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int g = 0;
        out_ready = 1'b1;
        while (((obs_out.size() - ob) < (plan_x.size() - pb) || out_valid) && g < 5000) begin
            tick();
            g++;
        end
        ok = ((obs_out.size() - ob) == (plan_x.size() - pb)) && !out_valid;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_x = 16'hFFFF; out_ready = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (exp_start !== 1'b0) begin failures++; $display("FAIL rst_exp_start got=%b exp=0", exp_start); end
        checks++; if (exp_x !== 16'h0) begin failures++; $display("FAIL rst_exp_x got=%h exp=0", exp_x); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 18'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_timeout); end
        checks++; if (done_cnt !== 8'h0) begin failures++; $display("FAIL rst_done_cnt got=%0d exp=0", done_cnt); end
        in_valid = 1'b0;
        rst = 1'b1;
        pb = plan_x.size(); ob = obs_out.size(); xb = obs_x.size(); chk = 0;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        bit ok; int pc, g, fv, s0; bit hold_bad;
        out_ready = 1'b0;
        s0 = n_starts;
        push_one(16'h8000, 10, 18'h1A612, ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL single_push got=blocked exp=accepted"); end
        g = 0;
        while (out_valid !== 1'b1 && g < 100) begin tick(); g++; end
        fv = cyc;
        checks++; if (start_cyc !== pc + 2) begin failures++; $display("FAIL single_start_cycle got=%0d exp=%0d", start_cyc, pc + 2); end
        checks++; if (fv !== pc + 13) begin failures++; $display("FAIL single_valid_cycle got=%0d exp=%0d", fv, pc + 13); end
        hold_bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 18'h1A612) hold_bad = 1'b1;
            tick();
        end
        checks++; if (hold_bad) begin failures++; $display("FAIL single_hold got=%b/%h exp=1/1a612", out_valid, out_data); end
        checks++; if (exp_x !== 16'h8000) begin failures++; $display("FAIL single_exp_x got=%h exp=8000", exp_x); end
        checks++; if (n_starts - s0 !== 1) begin failures++; $display("FAIL single_start_pulses got=%0d exp=1", n_starts - s0); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", out_valid); end
        checks++; if (done_cnt !== 8'd1) begin failures++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
        checks++; if (out_data !== 18'h1A612) begin failures++; $display("FAIL single_data_kept got=%h exp=1a612", out_data); end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_drain got=timeout exp=drained"); end
        for (int i = chk; i < obs_out.size() - ob && pb + i < plan_x.size(); i++) begin
            checks++; if (obs_out[ob + i] !== model_out(pb + i)) begin failures++; $display("FAIL single_out[%0d] got=%h exp=%h", i, obs_out[ob + i], model_out(pb + i)); end
        end
        chk = obs_out.size() - ob;
    endtask

    task automatic test_backpressure();
        bit ok; int pc; bit seen_ready;
        out_ready = 1'b0;
        for (int i = 0; i < DEP + 1; i++) begin
            push_one(16'($urandom), 3, 18'($urandom), ok, pc);
            checks++; if (!ok) begin failures++; $display("FAIL bp_push%0d got=blocked exp=accepted", i); end
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        in_valid = 1'b1; in_x = 16'hBEEF;
        seen_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready !== 1'b0) seen_ready = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (seen_ready) begin failures++; $display("FAIL bp_ready_while_full got=1 exp=0"); end
        checks++; if (obs_out.size() - ob !== chk) begin failures++; $display("FAIL bp_output_leak got=%0d exp=%0d", obs_out.size() - ob, chk); end
        out_ready = 1'b1;
        push_one(16'($urandom), 3, 18'($urandom), ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL bp_push_last got=blocked exp=accepted"); end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_drain got=timeout exp=drained"); end
        for (int i = chk; i < obs_out.size() - ob && pb + i < plan_x.size(); i++) begin
            checks++; if (obs_out[ob + i] !== model_out(pb + i)) begin failures++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, obs_out[ob + i], model_out(pb + i)); end
            checks++; if (xb + i < obs_x.size() && obs_x[xb + i] !== plan_x[pb + i]) begin failures++; $display("FAIL bp_x[%0d] got=%h exp=%h", i, obs_x[xb + i], plan_x[pb + i]); end
        end
        chk = obs_out.size() - ob;
        checks++; if (done_cnt !== 8'(plan_x.size() - pb)) begin failures++; $display("FAIL bp_done_cnt got=%0d exp=%0d", done_cnt, plan_x.size() - pb); end
    endtask

    task automatic test_timeout();
        bit ok; int pc;
        out_ready = 1'b1;
        push_one(16'h1234, TO, 18'h2ABCD, ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL to_push_edge got=blocked exp=accepted"); end
        drain(ok);
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_edge_err got=%b exp=0", err_timeout); end
        push_one(16'h4321, -1, 18'h3FFFF, ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL to_push_hang got=blocked exp=accepted"); end
        while (cyc < pc + 2 + TO) tick();
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_err_early got=%b exp=0", err_timeout); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL to_valid_early got=%b exp=0", out_valid); end
        tick();
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_err_set got=%b exp=1", err_timeout); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL to_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 18'h0) begin failures++; $display("FAIL to_data got=%h exp=0", out_data); end
        push_one(16'h0F0F, 7, 18'h15A5A, ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL to_push_next got=blocked exp=accepted"); end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_drain got=timeout exp=drained"); end
        for (int i = chk; i < obs_out.size() - ob && pb + i < plan_x.size(); i++) begin
            checks++; if (obs_out[ob + i] !== model_out(pb + i)) begin failures++; $display("FAIL to_out[%0d] got=%h exp=%h", i, obs_out[ob + i], model_out(pb + i)); end
        end
        chk = obs_out.size() - ob;
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
    endtask

    task automatic test_spurious();
        bit ok; int pc, g, s0; bit bad; logic [17:0] prev; logic [7:0] dc;
        out_ready = 1'b1;
        prev = out_data; s0 = n_starts; bad = 1'b0;
        spur_en = 1'b1; spur_val = 18'h2C3C3; spur_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b0 || out_data !== prev) bad = 1'b1;
        end
        spur_done = 1'b0; spur_en = 1'b0;
        tick();
        checks++; if (bad || out_valid !== 1'b0) begin failures++; $display("FAIL spur_idle got=%b/%h exp=0/%h", out_valid, out_data, prev); end
        checks++; if (n_starts !== s0) begin failures++; $display("FAIL spur_idle_start got=%0d exp=%0d", n_starts, s0); end
        out_ready = 1'b0;
        push_one(16'h7777, 4, 18'h0ACE1, ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL spur_push got=blocked exp=accepted"); end
        g = 0;
        while (out_valid !== 1'b1 && g < 100) begin tick(); g++; end
        dc = done_cnt; bad = 1'b0;
        spur_en = 1'b1; spur_val = 18'h3531E; spur_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 18'h0ACE1 || done_cnt !== dc) bad = 1'b1;
        end
        spur_done = 1'b0; spur_en = 1'b0;
        checks++; if (bad) begin failures++; $display("FAIL spur_hold got=%b/%h exp=1/0ace1", out_valid, out_data); end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL spur_drain got=timeout exp=drained"); end
        for (int i = chk; i < obs_out.size() - ob && pb + i < plan_x.size(); i++) begin
            checks++; if (obs_out[ob + i] !== model_out(pb + i)) begin failures++; $display("FAIL spur_out[%0d] got=%h exp=%h", i, obs_out[ob + i], model_out(pb + i)); end
        end
        chk = obs_out.size() - ob;
    endtask

    task automatic test_reset_mid();
        bit ok; int pc, s0; bit bad;
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL mid_err_before got=%b exp=1", err_timeout); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(16'($urandom), -1, 18'($urandom), ok, pc);
            checks++; if (!ok) begin failures++; $display("FAIL mid_push%0d got=blocked exp=accepted", i); end
        end
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        pb = plan_x.size(); ob = obs_out.size(); xb = obs_x.size(); chk = 0;
        #1;
        checks++; if (exp_start !== 1'b0) begin failures++; $display("FAIL mid_exp_start got=%b exp=0", exp_start); end
        checks++; if (exp_x !== 16'h0) begin failures++; $display("FAIL mid_exp_x got=%h exp=0", exp_x); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 18'h0) begin failures++; $display("FAIL mid_out_data got=%h exp=0", out_data); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", err_timeout); end
        checks++; if (done_cnt !== 8'h0) begin failures++; $display("FAIL mid_done_cnt got=%0d exp=0", done_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        s0 = n_starts; bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL mid_stray_valid got=1 exp=0"); end
        checks++; if (n_starts !== s0) begin failures++; $display("FAIL mid_stray_start got=%0d exp=%0d", n_starts, s0); end
    endtask

    task automatic test_random();
        bit ok; bit done_push; int base;
        done_push = 1'b0;
        base = chk;
        fork
            begin
                int pc; bit pok; int lat; int r;
                for (int i = 0; i < 40; i++) begin
                    for (int gap = $urandom_range(3, 0); gap > 0; gap--) tick();
                    r = $urandom_range(9, 0);
                    lat = (r == 0) ? -1 : int'($urandom_range(TO + 2, 1));
                    push_one(16'($urandom), lat, 18'($urandom), pok, pc);
                    checks++; if (!pok) begin failures++; $display("FAIL rnd_push%0d got=blocked exp=accepted", i); end
                end
                done_push = 1'b1;
            end
            begin
                int g = 0;
                while (!(done_push && (obs_out.size() - ob) >= (plan_x.size() - pb)) && g < 20000) begin
                    out_ready = 1'($urandom);
                    tick();
                    g++;
                end
                out_ready = 1'b1;
            end
        join
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rnd_drain got=timeout exp=drained"); end
        for (int i = base; i < obs_out.size() - ob && pb + i < plan_x.size(); i++) begin
            checks++; if (obs_out[ob + i] !== model_out(pb + i)) begin failures++; $display("FAIL rnd_out[%0d] got=%h exp=%h", i, obs_out[ob + i], model_out(pb + i)); end
            checks++; if (xb + i < obs_x.size() && obs_x[xb + i] !== plan_x[pb + i]) begin failures++; $display("FAIL rnd_x[%0d] got=%h exp=%h", i, obs_x[xb + i], plan_x[pb + i]); end
        end
        chk = obs_out.size() - ob;
        checks++; if (err_timeout !== model_err()) begin failures++; $display("FAIL rnd_err got=%b exp=%b", err_timeout, model_err()); end
        checks++; if (done_cnt !== 8'(plan_x.size() - pb)) begin failures++; $display("FAIL rnd_done_cnt got=%0d exp=%0d", done_cnt, plan_x.size() - pb); end
    endtask

    task automatic test_done_wrap();
        bit ok; int pc; int remaining;
        out_ready = 1'b1;
        remaining = 256 - (plan_x.size() - pb);
        for (int i = 0; i < remaining - 1; i++) begin
            push_one(16'($urandom), 1, 18'($urandom), ok, pc);
            checks++; if (!ok) begin failures++; $display("FAIL wrap_push%0d got=blocked exp=accepted", i); end
        end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_drain got=timeout exp=drained"); end
        checks++; if (done_cnt !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", done_cnt); end
        push_one(16'hFFFF, 2, 18'h3FFFF, ok, pc);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_push_last got=blocked exp=accepted"); end
        drain(ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrap_drain_last got=timeout exp=drained"); end
        checks++; if (done_cnt !== 8'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", done_cnt); end
        for (int i = chk; i < obs_out.size() - ob && pb + i < plan_x.size(); i++) begin
            checks++; if (obs_out[ob + i] !== model_out(pb + i)) begin failures++; $display("FAIL wrap_out[%0d] got=%h exp=%h", i, obs_out[ob + i], model_out(pb + i)); end
        end
        chk = obs_out.size() - ob;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_random();
        test_done_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
